// File: rtl/adder_self_check.sv
// -----------------------------------------------------------------------------
// adder_self_check
//
// Built-in self-test engine for the 1-bit full adder my_adder. It drives the
// adder inputs through all eight combinations. For each one it waits a settle
// time, samples the adder response and compares it against the full-adder
// truth computed here. At the end it reports pass/fail, a saturating error
// count and the index of the first failing vector.
//
// Parameters:
//   SETTLE_CYCLES - clock cycles between applying a vector and sampling the
//                   response; 0 removes the settle state entirely
//   CNT_W         - width of the settle counter (SETTLE_CYCLES < 2**CNT_W)
//   ERR_W         - width of err_count (>= 4 so eight errors fit)
//
// Ports:
//   clk       in   system clock, rising edge
//   rst       in   synchronous active-high reset
//   start     in   level; starts a run when sampled in IDLE or DONE
//   X, Y      out  adder operands (registered)
//   C_in      out  adder carry-in (registered)
//   Z         in   adder sum response
//   C_out     in   adder carry response
//   busy      out  high while a run is in progress
//   done      out  high in DONE until the next start or reset
//   pass      out  valid with done; 1 when no vector mismatched
//   err_count out  number of mismatching vectors, saturating
//   fail_vec  out  index of the first failing vector, 0 if none
//
// Build option:
//   ADDER_CHK_STOP_ON_FAIL_EN - when defined, the first mismatch ends the run
//   immediately. X/Y/C_in then keep the failing vector so it can be probed.
// -----------------------------------------------------------------------------
module adder_self_check #(
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = 4,
  parameter int ERR_W         = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             X,
  output logic             Y,
  output logic             C_in,
  input  logic             Z,
  input  logic             C_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [2:0]       fail_vec
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_APPLY,
    S_SETTLE,
    S_CHECK,
    S_DONE
  } state_t;

  // Last counter value spent in SETTLE. When SETTLE_CYCLES is 0 this wraps,
  // but SETTLE is never entered in that case.
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

  state_t           state;
  state_t           state_nxt;
  logic [2:0]       v;
  logic [CNT_W-1:0] cnt;
  logic             first_fail;
  logic             exp_z;
  logic             exp_c;
  logic             mismatch;

  // Reference full adder, evaluated on the operands actually being driven.
  assign exp_z    = X ^ Y ^ C_in;
  assign exp_c    = (X & Y) | (X & C_in) | (Y & C_in);
  assign mismatch = (Z != exp_z) || (C_out != exp_c);

  // Status flags decode straight from the state. pass therefore needs no
  // separate register and can never be stale.
  assign busy = (state == S_APPLY) || (state == S_SETTLE) || (state == S_CHECK);
  assign done = (state == S_DONE);
  assign pass = done && (err_count == '0);

  // Next-state logic. IDLE and DONE accept start identically, so a finished
  // run can be relaunched without going through reset.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_APPLY;
      end
      S_APPLY: begin
        state_nxt = (SETTLE_CYCLES == 0) ? S_CHECK : S_SETTLE;
      end
      S_SETTLE: begin
        if (cnt == SETTLE_LAST) state_nxt = S_CHECK;
      end
      S_CHECK: begin
        if (v == 3'd7) state_nxt = S_DONE;
        else           state_nxt = S_APPLY;
`ifdef ADDER_CHK_STOP_ON_FAIL_EN
        if (mismatch) state_nxt = S_DONE;
`endif
      end
      S_DONE: begin
        if (start) state_nxt = S_APPLY;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Datapath registers. The operands load at the end of APPLY, so the adder
  // sees the new vector for the whole settle window. The results change only
  // in CHECK or on a new start, which keeps them readable at any time.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      v          <= 3'd0;
      cnt        <= '0;
      first_fail <= 1'b0;
      X          <= 1'b0;
      Y          <= 1'b0;
      C_in       <= 1'b0;
      err_count  <= '0;
      fail_vec   <= 3'd0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            v          <= 3'd0;
            err_count  <= '0;
            fail_vec   <= 3'd0;
            first_fail <= 1'b0;
          end
        end
        S_APPLY: begin
          X    <= v[0];
          Y    <= v[1];
          C_in <= v[2];
          cnt  <= '0;
        end
        S_SETTLE: begin
          cnt <= cnt + 1'b1;
        end
        S_CHECK: begin
          if (mismatch) begin
            if (err_count != '1) err_count <= err_count + 1'b1;
            if (!first_fail) begin
              fail_vec   <= v;
              first_fail <= 1'b1;
            end
          end
          if (v != 3'd7) v <= v + 3'd1;
        end
        default: ;
      endcase
    end
  end

endmodule
